// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined instruction-decode stage with register file and ID/EX register
module id_stage_pipe #(
  parameter int DATA_W = 16,
  parameter bit BYPASS = 1'b1,
  parameter bit HAZARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [1:0]        dst_sel,
  input  logic [1:0]        imm_sel,
  input  logic              reg_write_ctl,
  input  logic              mem_read_ctl,
  input  logic              uses_rs,
  input  logic              uses_rt,
  input  logic              ex_stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_tgt,
  output logic [2:0]        ex_dst_reg
);

  // Instruction fields
  logic [2:0] rs;
  logic [2:0] rt;
  logic [2:0] rd;
  assign rs = if_instr[10:8];
  assign rt = if_instr[7:5];
  assign rd = if_instr[4:2];

  // Opcode bits are decoded upstream into the *_ctl/*_sel inputs.
  logic unused_opcode;
  assign unused_opcode = ^if_instr[15:11];

  // Register file: 8 general registers, R0 is not hard-wired.
  logic [DATA_W-1:0] rf [8];

  // Write-back port updates the array on the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_en) begin
      rf[wb_reg] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  // Combinational reads; optionally forward a write landing this same cycle
  always_comb begin
    rs_data = rf[rs];
    rt_data = rf[rt];
    if (BYPASS && wb_en) begin
      if (wb_reg == rs) rs_data = wb_data;
      if (wb_reg == rt) rt_data = wb_data;
    end
  end

  logic [DATA_W-1:0] imm;

  // Immediate extraction and extension to the datapath width
  always_comb begin
    imm = '0;
    case (imm_sel)
      2'b00:   imm = {{(DATA_W-5){if_instr[4]}},  if_instr[4:0]};
      2'b01:   imm = {{(DATA_W-8){if_instr[7]}},  if_instr[7:0]};
      2'b10:   imm = {{(DATA_W-8){1'b0}},         if_instr[7:0]};
      default: imm = {{(DATA_W-11){if_instr[10]}}, if_instr[10:0]};
    endcase
  end

  logic [DATA_W-1:0] tgt;
  // Branch/jump target relative to the following instruction; wraps naturally
  assign tgt = if_pc + DATA_W'(2) + imm;

  logic [2:0] dst_reg;

  // Destination register select; 11 is the link register R7
  always_comb begin
    dst_reg = rs;
    case (dst_sel)
      2'b00:   dst_reg = rs;
      2'b01:   dst_reg = rd;
      2'b10:   dst_reg = rt;
      default: dst_reg = 3'd7;
    endcase
  end

  logic hz;

  // Load-use: the consumer in ID needs a register a load in EX has not produced yet
  always_comb begin
    hz = 1'b0;
    if (HAZARD) begin
      hz = if_valid & ex_valid & ex_mem_read & ex_reg_write &
           ((uses_rs & (rs == ex_dst_reg)) | (uses_rt & (rt == ex_dst_reg)));
    end
  end

  assign id_stall = HAZARD ? (hz | ex_stall) : 1'b0;

  logic load_ex;
  assign load_ex = !flush && !ex_stall && !hz;

  // ID/EX control fields: flush beats stall beats bubble beats load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (ex_stall) begin
      ex_valid     <= ex_valid;
      ex_reg_write <= ex_reg_write;
      ex_mem_read  <= ex_mem_read;
    end else if (hz) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_valid     <= if_valid;
      ex_reg_write <= if_valid & reg_write_ctl;
      ex_mem_read  <= if_valid & mem_read_ctl;
    end
  end

  // ID/EX data fields only load on a normal advance; otherwise they hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_tgt     <= '0;
      ex_dst_reg <= 3'd0;
    end else if (load_ex) begin
      ex_rs_data <= rs_data;
      ex_rt_data <= rt_data;
      ex_imm     <= imm;
      ex_pc      <= if_pc;
      ex_tgt     <= tgt;
      ex_dst_reg <= dst_reg;
    end
  end

endmodule
